// File: rtl/core_pkg.sv
// Shared core constants and writeback source encoding used by the
// writeback arbiter, its scoreboard, and trace hooks.
package core_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LSU  = 2'd2,
      WB_MDU  = 2'd3
   } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for long-latency writes; a set beats a
// same-cycle clear, and re-issuing to a pending register flags a conflict.
module wb_scoreboard
   import core_pkg::*;
#(
   parameter int NREG_P = NREG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_valid,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_valid,
   input  logic [REG_AW-1:0] clr_idx,
   output logic [NREG_P-1:0] pend,
   output logic              pend_conflict
);

   logic [NREG_P-1:0] pend_q;
   logic [NREG_P-1:0] pend_d;
   logic              conflict_d;
   logic              conflict_q;

   always_comb begin
      pend_d     = pend_q;
      conflict_d = 1'b0;
      if (clr_valid) begin
         pend_d[clr_idx] = 1'b0;
      end
      if (set_valid && (set_idx != '0)) begin
         pend_d[set_idx] = 1'b1;
         conflict_d      = pend_q[set_idx];
      end
      // x0 is never a real destination, so it can never be pending
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         conflict_q <= conflict_d;
      end
   end

   assign pend          = pend_q;
   assign pend_conflict = conflict_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU, LSU and MDU writebacks onto the single register-file write
// port through a one-cycle writeback stage, and tracks pending destinations.
module regfile_wb_arbiter
   import core_pkg::*;
#(
   parameter int XLEN_P = XLEN,
   parameter int NREG_P = NREG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN_P-1:0] alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN_P-1:0] lsu_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [XLEN_P-1:0] mdu_data,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              wb_wen,
   output logic [REG_AW-1:0] wb_waddr,
   output logic [XLEN_P-1:0] wb_wdata,
   output logic [NREG_P-1:0] pend,
   output logic              pend_conflict
);

   logic              rr_q;
   logic              lsu_fire;
   logic              mdu_fire;
   wb_src_e           src;
   logic [REG_AW-1:0] sel_rd;
   logic [XLEN_P-1:0] sel_data;
   logic              wen_q;
   logic [REG_AW-1:0] waddr_q;
   logic [XLEN_P-1:0] wdata_q;
   logic              clr_valid;
   logic [REG_AW-1:0] clr_idx;

   // rr only breaks ties; a lone slow requester is always ready when the ALU is idle
   assign lsu_ready = !alu_valid && (!mdu_valid || (rr_q == 1'b0));
   assign mdu_ready = !alu_valid && (!lsu_valid || (rr_q == 1'b1));
   assign lsu_fire  = lsu_valid && lsu_ready;
   assign mdu_fire  = mdu_valid && mdu_ready;

   always_comb begin
      src      = WB_NONE;
      sel_rd   = '0;
      sel_data = '0;
      if (alu_valid) begin
         src = WB_ALU;
      end else if (lsu_fire) begin
         src = WB_LSU;
      end else if (mdu_fire) begin
         src = WB_MDU;
      end
      case (src)
         WB_ALU: begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
         end
         WB_LSU: begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
         end
         WB_MDU: begin
            sel_rd   = mdu_rd;
            sel_data = mdu_data;
         end
         default: begin
            sel_rd   = '0;
            sel_data = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q    <= 1'b0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         if ((lsu_fire || mdu_fire) && lsu_valid && mdu_valid) begin
            rr_q <= ~rr_q;
         end
         wen_q <= (src != WB_NONE) && (sel_rd != '0);
         if (src != WB_NONE) begin
            waddr_q <= sel_rd;
            wdata_q <= sel_data;
         end
      end
   end

   // Gating with reset keeps an in-flight write from committing in the reset cycle
   assign wb_wen   = wen_q && !reset;
   assign wb_waddr = waddr_q;
   assign wb_wdata = wdata_q;

   assign clr_valid = lsu_fire || mdu_fire;
   assign clr_idx   = lsu_fire ? lsu_rd : mdu_rd;

   wb_scoreboard #(
      .NREG_P(NREG_P)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .set_valid    (iss_valid),
      .set_idx      (iss_rd),
      .clr_valid    (clr_valid),
      .clr_idx      (clr_idx),
      .pend         (pend),
      .pend_conflict(pend_conflict)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [31:0] pend;
   logic        pend_conflict;

   int n_chk  = 0;
   int n_pass = 0;

   regfile_wb_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .mdu_valid    (mdu_valid),
      .mdu_ready    (mdu_ready),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .wb_wen       (wb_wen),
      .wb_waddr     (wb_waddr),
      .wb_wdata     (wb_wdata),
      .pend         (pend),
      .pend_conflict(pend_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   logic [4:0] exp_addr [4];

   initial begin
      exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd1; exp_addr[3] = 5'd2;
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_wen", wb_wen, 0);
      chk("rst_waddr", wb_waddr, 0);
      chk("rst_wdata", wb_wdata, 0);
      chk("rst_pend", pend, 0);
      chk("rst_conflict", pend_conflict, 0);

      // ALU write to x5
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
      #1;
      chk("alu_lsu_ready", lsu_ready, 0);
      chk("alu_mdu_ready", mdu_ready, 0);
      tick();
      idle_inputs();
      chk("alu_wen", wb_wen, 1);
      chk("alu_waddr", wb_waddr, 5);
      chk("alu_wdata", wb_wdata, 32'hDEADBEEF);

      // ALU write to x0 produces no write
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      tick();
      idle_inputs();
      chk("x0_wen", wb_wen, 0);

      // Both slow sources valid: alternate starting with LSU
      lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
      mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_lsu_ready", lsu_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_mdu_ready", mdu_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         chk("rr_wen", wb_wen, 1);
         chk("rr_waddr", wb_waddr, exp_addr[i]);
         chk("rr_wdata", wb_wdata, (i % 2 == 0) ? 32'h11 : 32'h22);
      end
      idle_inputs();

      // Issue x7, load returns three cycles later
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      idle_inputs();
      chk("iss7_pend", pend[7], 1);
      tick();
      chk("iss7_pend_n2", pend[7], 1);
      tick();
      chk("iss7_pend_n3", pend[7], 1);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h55;
      #1;
      chk("ld7_ready", lsu_ready, 1);
      tick();
      idle_inputs();
      chk("ld7_wen", wb_wen, 1);
      chk("ld7_waddr", wb_waddr, 7);
      chk("ld7_wdata", wb_wdata, 32'h55);
      chk("ld7_pend", pend[7], 0);

      // Set beats a same-cycle clear on x9, then a re-issue conflicts
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      idle_inputs();
      chk("iss9_pend", pend[9], 1);
      iss_valid = 1'b1; iss_rd = 5'd9;
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
      #1;
      chk("md9_ready", mdu_ready, 1);
      tick();
      idle_inputs();
      chk("setclr9_pend", pend[9], 1);
      chk("md9_waddr", wb_waddr, 9);
      chk("md9_wen", wb_wen, 1);
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      idle_inputs();
      chk("conflict9", pend_conflict, 1);
      chk("conflict9_pend", pend[9], 1);
      tick();
      chk("conflict9_drop", pend_conflict, 0);

      // Reset right after an LSU grant discards the write
      iss_valid = 1'b1; iss_rd = 5'd3;
      tick();
      idle_inputs();
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hAA;
      tick();
      idle_inputs();
      reset = 1'b1;
      #1;
      chk("rst_mid_wen_now", wb_wen, 0);
      tick();
      chk("rst_mid_wen", wb_wen, 0);
      chk("rst_mid_pend", pend, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_wen", wb_wen, 0);
      chk("post_rst_pend", pend, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side companion to the core register file: merges writebacks from the single-cycle ALU pipe and the two long-latency units (LSU load return, MDU) onto the register file's single write port. Registers the selected write into a one-cycle writeback stage whose outputs connect directly to the register file's wen/waddr/wdata inputs. Also maintains a 32-bit pending-destination scoreboard that the issue stage uses for hazard stalls.

## Interface

- XLEN, default 32, data width
- NREG, default 32, architectural registers; address width is log2(NREG) = 5

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid; no backpressure, always accepted
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid / lsu_ready  in / out  1 / 1  load-return handshake
- lsu_rd, lsu_data  in  5, XLEN  load destination and data
- mdu_valid / mdu_ready  in / out  1 / 1  MDU-result handshake
- mdu_rd, mdu_data  in  5, XLEN  MDU destination and data
- iss_valid  in  1  long-latency op (load or MDU) issued this cycle
- iss_rd  in  5  its destination
- wb_wen  out  1  to register-file wen
- wb_waddr  out  5  to register-file waddr
- wb_wdata  out  XLEN  to register-file wdata
- pend  out  NREG  scoreboard; bit i set means a long-latency write to xi is outstanding
- pend_conflict  out  1  one-cycle pulse: issue targeted an already-pending rd

## Operation

- Grant per cycle, combinational from current inputs and rr pointer:
  - alu_valid has absolute priority; lsu_ready = mdu_ready = 0 that cycle.
  - Otherwise lsu_ready = !alu_valid && (!mdu_valid || rr==0); mdu_ready = !alu_valid && (!lsu_valid || rr==1).
  - Ready must not depend on the requester's own valid, except through the rr tie-break.
- rr flips to the other slow source after every slow-source grant that occurs while both slow sources were valid. It is unchanged otherwise.
- The granted source's rd/data are loaded into the writeback register. wb_wen = 1 iff a grant occurred and rd != 0. A handshake on rd = 0 completes normally but produces no write.
- Scoreboard:
  - On iss_valid with iss_rd != 0, set pend[iss_rd].
  - On an accepted LSU or MDU handshake, clear pend[rd].
  - ALU writes never touch pend.
  - If a set and a clear hit the same index in the same cycle, the set wins.
  - If iss_valid targets an index already set, pend_conflict pulses and the bit stays 1.
- pend[0] is constantly 0.

## Timing

- Reset values: wb_wen=0, wb_waddr=0, wb_wdata=0, pend=0, pend_conflict=0, rr=0 (LSU favoured).
- Reset mid-operation: any in-flight writeback register content is discarded; the write is not performed. The scoreboard clears in the same cycle.
- Latency: a grant in cycle N drives wb_* in cycle N+1; the register file commits at the end of N+1.
- The pend clear for a slow grant in cycle N is visible from cycle N+1. This is the same cycle wb_wen is high, so a reader released by pend=0 obtains the value through the register file's same-cycle write bypass.
- iss_valid in cycle N makes pend[iss_rd]=1 from N+1.
- Throughput: one write per cycle. With sustained alu_valid, slow sources stall indefinitely; the core guarantees ALU bubbles.
- pend_conflict is registered: it is high in N+1 for a conflict detected in N.

## Structure

- Shared package core_pkg holds XLEN, NREG, REG_AW=5, and the wb_src_e enum (WB_NONE, WB_ALU, WB_LSU, WB_MDU) used by the grant mux and trace hooks.
- Sub-module wb_scoreboard holds the pend vector, set/clear priority and conflict detection. The arbiter top holds the grant logic, rr flop and writeback register.

## Test plan

- Reset, then idle: all outputs 0. Then alu_valid, rd=5, data=0xDEADBEEF for one cycle: next cycle wb_wen=1, waddr=5, wdata=0xDEADBEEF; lsu_ready=0 during the ALU cycle.
- ALU write to rd=0 with data 0x1234: wb_wen stays 0 the following cycle.
- lsu and mdu both valid for 4 cycles with no ALU traffic: grants alternate LSU, MDU, LSU, MDU; wb_waddr follows that order 1 cycle later.
- iss rd=7; 3 cycles later LSU returns rd=7, data 0x55: pend[7]=1 until the cycle wb_wen=1 with waddr=7, in which pend[7]=0.
- Same cycle: iss rd=9 and MDU handshake rd=9 with pend[9]=1 beforehand: pend[9] remains 1. A second iss rd=9 then produces a pend_conflict pulse.
- Reset asserted the cycle after an LSU grant: wb_wen=0 the next cycle and pend=0.
